sdram_upload: RTL and testbench

//  Read-side counterpart of the ROM/BIOS download loader. Streams a SDRAM region back to the HPS over
//  the ioctl upload channel (save RAM / memory dump). Reads one 32-bit SDRAM word at a time, splits it

---
 rtl/sdram_upload.sv | 215 +++++++++++++++++++++
 tb/tb_sdram_upload.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_upload.sv
// sdram_upload: streams an SDRAM region back to the HPS over the ioctl upload channel.
// Each 32-bit SDRAM word is fetched once, buffered, and returned as two 16-bit ioctl
// words (low half first). ioctl_wait holds the HPS off while a missing word is fetched.
// Optional feature macro: UPLOAD_PREFETCH_EN. When it is defined, serving a high half
// starts a fetch of the next word, so a sequential upload only stalls on its first word.
// Ports:
//   clk_cpu, reset           clock, synchronous active-high reset
//   ioctl_upload/index/rd/addr  HPS upload request side
//   ioctl_din, ioctl_wait    data and stall back to the HPS
//   busy                     uploader owns the SDRAM read port
//   sdram_raddr, sdram_rd    read request to the SDRAM controller
//   sdram_rd_rdy, sdram_dout controller idle / read data
module sdram_upload #(
    parameter logic [24:0] BASE_ADDR = 25'h0100000,
    parameter logic [24:0] SIZE      = 25'h0010000,
    parameter logic [5:0]  INDEX     = 6'h02
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [15:0] ioctl_din,
    output logic        ioctl_wait,
    output logic        busy,
    output logic [24:0] sdram_raddr,
    output logic        sdram_rd,
    input  logic        sdram_rd_rdy,
    input  logic [31:0] sdram_dout
);

    localparam int unsigned AW = 25;
    localparam int unsigned TW = 23;
`ifdef UPLOAD_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_HI} state_t;

    state_t          state_q, state_d;
    logic            active_q, active_d;
    logic [31:0]     wbuf_q, wbuf_d;
    logic [TW-1:0]   wtag_q, wtag_d;
    logic            wvalid_q, wvalid_d;
    logic [TW-1:0]   fetch_tag_q, fetch_tag_d;
    logic [TW-1:0]   req_tag_q, req_tag_d;
    logic            req_half_q, req_half_d;
    logic            pend_q, pend_d;
    logic [15:0]     din_q, din_d;
    logic            wait_q, wait_d;
    logic            busy_q, busy_d;
    logic            rd_q, rd_d;
    logic [AW-1:0]   raddr_q, raddr_d;

    logic            active_c, rise_c, fill_c, accept_c;
    logic [TW-1:0]   rd_tag_c;
    logic            served_hi_c;
    logic [TW-1:0]   served_tag_c;
    logic [AW-1:0]   next_addr_c;

    logic unused_c;
    assign unused_c = ^{ioctl_addr[0], ioctl_index[7:6]};

    assign active_c = ioctl_upload && (ioctl_index[5:0] == INDEX);
    assign rise_c   = active_c && !active_q;
    assign fill_c   = (state_q == S_WAIT_HI) && sdram_rd_rdy;
    assign accept_c = active_c && ioctl_rd && !wait_q;
    assign rd_tag_c = ioctl_addr[24:2];

    function automatic logic [15:0] pick_half(input logic [31:0] w, input logic hi);
        return hi ? w[31:16] : w[15:0];
    endfunction

    // State registers
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state_q     <= S_IDLE;
            active_q    <= 1'b0;
            wbuf_q      <= '0;
            wtag_q      <= '0;
            wvalid_q    <= 1'b0;
            fetch_tag_q <= '0;
            req_tag_q   <= '0;
            req_half_q  <= 1'b0;
            pend_q      <= 1'b0;
            din_q       <= '0;
            wait_q      <= 1'b0;
            busy_q      <= 1'b0;
            rd_q        <= 1'b0;
            raddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            wbuf_q      <= wbuf_d;
            wtag_q      <= wtag_d;
            wvalid_q    <= wvalid_d;
            fetch_tag_q <= fetch_tag_d;
            req_tag_q   <= req_tag_d;
            req_half_q  <= req_half_d;
            pend_q      <= pend_d;
            din_q       <= din_d;
            wait_q      <= wait_d;
            busy_q      <= busy_d;
            rd_q        <= rd_d;
            raddr_q     <= raddr_d;
        end
    end

    // Next-state: fetch FSM, buffer lookup, request servicing
    always_comb begin
        state_d      = state_q;
        active_d     = active_c;
        wbuf_d       = wbuf_q;
        wtag_d       = wtag_q;
        wvalid_d     = wvalid_q;
        fetch_tag_d  = fetch_tag_q;
        req_tag_d    = req_tag_q;
        req_half_d   = req_half_q;
        pend_d       = pend_q;
        din_d        = din_q;
        wait_d       = wait_q;
        rd_d         = 1'b0;
        raddr_d      = raddr_q;
        served_hi_c  = 1'b0;
        served_tag_c = '0;
        next_addr_c  = '0;

        if (rise_c) wvalid_d = 1'b0;

        case (state_q)
            S_ISSUE: begin
                if (sdram_rd_rdy) begin
                    rd_d    = 1'b1;
                    raddr_d = BASE_ADDR + {fetch_tag_q, 2'b00};
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: if (!sdram_rd_rdy) state_d = S_WAIT_HI;
            S_WAIT_HI: begin
                if (sdram_rd_rdy) begin
                    state_d = S_IDLE;
                    // Data from a session that has ended is dropped
                    if (active_c) begin
                        wbuf_d   = sdram_dout;
                        wtag_d   = fetch_tag_q;
                        wvalid_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Finish a stalled request; a prefetch of another word is followed by its own read
        if (fill_c && pend_q && active_c) begin
            if (fetch_tag_q == req_tag_q) begin
                din_d        = pick_half(sdram_dout, req_half_q);
                wait_d       = 1'b0;
                pend_d       = 1'b0;
                served_hi_c  = req_half_q;
                served_tag_c = req_tag_q;
            end else begin
                state_d     = S_ISSUE;
                fetch_tag_d = req_tag_q;
            end
        end

        if (accept_c) begin
            if (ioctl_addr >= SIZE) begin
                din_d = '0;
            end else if (fill_c && fetch_tag_q == rd_tag_c) begin
                // Word arriving this cycle: forward straight from the controller
                din_d        = pick_half(sdram_dout, ioctl_addr[1]);
                served_hi_c  = ioctl_addr[1];
                served_tag_c = rd_tag_c;
            end else if (wvalid_q && !rise_c && wtag_q == rd_tag_c) begin
                din_d        = pick_half(wbuf_q, ioctl_addr[1]);
                served_hi_c  = ioctl_addr[1];
                served_tag_c = rd_tag_c;
            end else begin
                wait_d     = 1'b1;
                pend_d     = 1'b1;
                req_tag_d  = rd_tag_c;
                req_half_d = ioctl_addr[1];
                if (state_q == S_IDLE || fill_c) begin
                    state_d     = S_ISSUE;
                    fetch_tag_d = rd_tag_c;
                end
            end
        end

        // Fetch the following word once the current one is fully consumed
        next_addr_c = {served_tag_c, 2'b00} + 25'd4;
        if (PREFETCH && served_hi_c && state_d == S_IDLE && next_addr_c < SIZE) begin
            state_d     = S_ISSUE;
            fetch_tag_d = served_tag_c + 23'd1;
        end

        if (!active_c) begin
            wait_d = 1'b0;
            pend_d = 1'b0;
        end

        busy_d = active_c || (state_d != S_IDLE);
    end

    assign ioctl_din   = din_q;
    assign ioctl_wait  = wait_q;
    assign busy        = busy_q;
    assign sdram_rd    = rd_q;
    assign sdram_raddr = raddr_q;

endmodule

// File: tb/tb_sdram_upload.sv
// Directed testbench for sdram_upload with a small SDRAM controller model.
module tb_sdram_upload;

    localparam logic [24:0] BASE = 25'h0100000;
`ifdef UPLOAD_PREFETCH_EN
    localparam bit PF = 1'b1;
`else
    localparam bit PF = 1'b0;
`endif

    logic        clk_cpu = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = 8'h02;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [15:0] ioctl_din;
    logic        ioctl_wait;
    logic        busy;
    logic [24:0] sdram_raddr;
    logic        sdram_rd;
    logic        sdram_rd_rdy;
    logic [31:0] sdram_dout;

    int checks = 0;
    int failures = 0;

    // SDRAM model state
    logic        m_rdy = 1'b1;
    logic [31:0] m_dout = '0;
    logic [24:0] m_addr = '0;
    logic [24:0] last_raddr = '0;
    int          m_cnt = 0;
    int          rd_count = 0;
    logic        hold = 1'b0;

    assign sdram_rd_rdy = m_rdy;
    assign sdram_dout   = m_dout;

    always #5 clk_cpu = ~clk_cpu;

    sdram_upload dut (
        .clk_cpu      (clk_cpu),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .busy         (busy),
        .sdram_raddr  (sdram_raddr),
        .sdram_rd     (sdram_rd),
        .sdram_rd_rdy (sdram_rd_rdy),
        .sdram_dout   (sdram_dout)
    );

    function automatic logic [31:0] mem_word(input logic [24:0] a);
        if (a == BASE) return 32'hDEADBEEF;
        return {8'hC0, a[7:0], 8'h5A, a[7:0]};
    endfunction

    // Controller: rdy drops after a strobe, data returns 4 cycles later unless held
    always @(posedge clk_cpu) begin
        if (sdram_rd) begin
            m_addr     <= sdram_raddr;
            last_raddr <= sdram_raddr;
            m_rdy      <= 1'b0;
            m_cnt      <= 3;
            rd_count   <= rd_count + 1;
        end else if (!m_rdy && !hold) begin
            if (m_cnt == 0) begin
                m_rdy  <= 1'b1;
                m_dout <= mem_word(m_addr);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic step();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_rd(input logic [24:0] a);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        step();
        ioctl_rd   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (ioctl_wait && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_wait_timeout"}, 32'(ioctl_wait), 32'd0);
    endtask

    task automatic wait_rdy(input logic level, input string tag);
        int n = 0;
        while (sdram_rd_rdy !== level && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_rdy_timeout"}, 32'(sdram_rd_rdy), 32'(level));
    endtask

    task automatic new_session();
        ioctl_upload = 1'b0;
        repeat (3) step();
        ioctl_upload = 1'b1;
        repeat (2) step();
    endtask

    initial begin
        int rd0;
        int waits;
        logic w;
        logic [24:0] wa;
        logic [31:0] ew;

        // Reset state
        repeat (3) step();
        chk("rst_din", 32'(ioctl_din), 32'd0);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sdram_rd", 32'(sdram_rd), 32'd0);
        chk("rst_raddr", 32'(sdram_raddr), 32'd0);
        reset = 1'b0;
        step();

        // 1: first read misses and fetches BASE
        ioctl_upload = 1'b1;
        repeat (2) step();
        chk("t1_busy", 32'(busy), 32'd1);
        rd0 = rd_count;
        do_rd(25'h0);
        chk("t1_wait", 32'(ioctl_wait), 32'd1);
        wait_done("t1");
        chk("t1_din", 32'(ioctl_din), 32'h0000BEEF);
        chk("t1_raddr", 32'(last_raddr), 32'h00100000);
        chk("t1_rdcount", 32'(rd_count - rd0), 32'd1);

        // 2: high half of the same word is a hit
        rd0 = rd_count;
        do_rd(25'h2);
        chk("t2_wait", 32'(ioctl_wait), 32'd0);
        chk("t2_din", 32'(ioctl_din), 32'h0000DEAD);
        repeat (10) step();
        chk("t2_rdcount", 32'(rd_count - rd0), PF ? 32'd1 : 32'd0);

        // 3: sequential upload of the first 16 ioctl words
        new_session();
        waits = 0;
        for (int i = 0; i < 16; i++) begin
            wa = 25'(i * 2);
            do_rd(wa);
            w = ioctl_wait;
            if (w) waits++;
            chk($sformatf("t3_wait_%0h", wa), 32'(w), PF ? 32'(wa == 25'h0) : 32'(!wa[1]));
            wait_done("t3");
            ew = mem_word(BASE + {wa[24:2], 2'b00});
            chk($sformatf("t3_din_%0h", wa), 32'(ioctl_din), wa[1] ? 32'(ew[31:16]) : 32'(ew[15:0]));
            repeat (10) step();
        end
        chk("t3_waits", 32'(waits), PF ? 32'd1 : 32'd8);

        // 4: address at SIZE reads zero without touching SDRAM
        rd0 = rd_count;
        do_rd(25'h0010000);
        chk("t4_din", 32'(ioctl_din), 32'd0);
        chk("t4_wait", 32'(ioctl_wait), 32'd0);
        repeat (5) step();
        chk("t4_rdcount", 32'(rd_count - rd0), 32'd0);

        // 5: upload drops while a read is in flight
        hold = 1'b1;
        do_rd(25'h100);
        chk("t5_wait", 32'(ioctl_wait), 32'd1);
        wait_rdy(1'b0, "t5a");
        step();
        ioctl_upload = 1'b0;
        step();
        chk("t5_wait_drop", 32'(ioctl_wait), 32'd0);
        chk("t5_busy_hold", 32'(busy), 32'd1);
        repeat (3) step();
        chk("t5_busy_hold2", 32'(busy), 32'd1);
        hold = 1'b0;
        wait_rdy(1'b1, "t5b");
        repeat (2) step();
        chk("t5_busy_release", 32'(busy), 32'd0);

        // 6: reset while waiting for read data
        ioctl_upload = 1'b1;
        repeat (2) step();
        hold = 1'b1;
        do_rd(25'h0);
        chk("t6_wait", 32'(ioctl_wait), 32'd1);
        wait_rdy(1'b0, "t6a");
        repeat (2) step();
        reset = 1'b1;
        step();
        chk("t6_din", 32'(ioctl_din), 32'd0);
        chk("t6_wait_rst", 32'(ioctl_wait), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_sdram_rd", 32'(sdram_rd), 32'd0);
        chk("t6_raddr", 32'(sdram_raddr), 32'd0);
        step();
        hold = 1'b0;
        repeat (8) step();
        reset = 1'b0;
        repeat (2) step();
        rd0 = rd_count;
        do_rd(25'h0);
        chk("t6_refetch_wait", 32'(ioctl_wait), 32'd1);
        wait_done("t6");
        chk("t6_refetch_din", 32'(ioctl_din), 32'h0000BEEF);
        chk("t6_refetch_cnt", 32'(rd_count - rd0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
